// File: rtl/ebpf_serial_addsub.sv
// ebpf_serial_addsub: bit-serial WIDTH-bit add/subtract unit for the eBPF ALU.
// Operands are pushed LSB-first through one full-adder cell, one bit per clock.
//
// Optional build macro: EBPF_ALU32_EN adds the alu32 port (32-bit op with
// zero-extended result; requires WIDTH == 64).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (op_a, op_b, sub[, alu32])
//   out_valid / out_ready result handshake (result, carry_out, overflow)
//   busy                  high while an operation is in RUN or DONE
module ebpf_serial_addsub #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
`ifdef EBPF_ALU32_EN
    input  logic             alu32,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_FULL = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
`ifdef EBPF_ALU32_EN
    logic             alu32_q;
`endif

    logic             sum_c;
    logic             cout_c;
    logic             last_c;
    logic [CW-1:0]    last_idx_c;
    logic [WIDTH-1:0] final_c;

    // Full-adder cell, last-bit detect and next-state decode
    always_comb begin
        state_nxt  = state;
        sum_c      = a_sh[0] ^ b_sh[0] ^ carry;
        cout_c     = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
`ifdef EBPF_ALU32_EN
        last_idx_c = alu32_q ? CW'(31) : LAST_FULL;
        // In 32-bit mode bits 0..30 sit in res_sh[WIDTH-2:WIDTH-32] after 31 shifts
        final_c    = alu32_q ? {{(WIDTH-32){1'b0}}, sum_c, res_sh[WIDTH-2:WIDTH-32]}
                             : {sum_c, res_sh};
`else
        last_idx_c = LAST_FULL;
        final_c    = {sum_c, res_sh};
`endif
        last_c     = (cnt == last_idx_c);

        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_RUN;
            S_RUN:   if (last_c)    state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef EBPF_ALU32_EN
            alu32_q   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + 1: invert B here, seed carry with sub
                        a_sh  <= op_a;
                        b_sh  <= op_b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
`ifdef EBPF_ALU32_EN
                        alu32_q <= alu32;
`endif
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= (WIDTH-1)'({sum_c, res_sh} >> 1);
                    carry  <= cout_c;
                    if (last_c) begin
                        // carry still holds the carry into the MSB here
                        result    <= final_c;
                        carry_out <= cout_c;
                        overflow  <= carry ^ cout_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ebpf_serial_addsub.sv
module tb_ebpf_serial_addsub;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             busy;
`ifdef EBPF_ALU32_EN
    logic             alu32;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    ebpf_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
`ifdef EBPF_ALU32_EN
        .alu32     (alu32),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic in a wider type
    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic s, input logic w32,
                                      output logic [63:0] r, output logic c,
                                      output logic v);
        logic [64:0]        u64;
        logic signed [65:0] s64;
        logic [32:0]        u32;
        logic signed [33:0] s32;
        if (w32) begin
            u32 = s ? ({1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1)
                    : ({1'b0, a[31:0]} + {1'b0, b[31:0]});
            s32 = s ? ($signed({{2{a[31]}}, a[31:0]}) - $signed({{2{b[31]}}, b[31:0]}))
                    : ($signed({{2{a[31]}}, a[31:0]}) + $signed({{2{b[31]}}, b[31:0]}));
            r = {32'd0, u32[31:0]};
            c = u32[32];
            v = !(s32[33:31] == 3'b000 || s32[33:31] == 3'b111);
        end else begin
            u64 = s ? ({1'b0, a} + {1'b0, ~b} + 65'd1) : ({1'b0, a} + {1'b0, b});
            s64 = s ? ($signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}))
                    : ($signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}));
            r = u64[63:0];
            c = u64[64];
            v = !(s64[65:63] == 3'b000 || s64[65:63] == 3'b111);
        end
    endfunction

    // One transaction: hold = cycles of back-pressure, disturb = pulse in_valid mid-RUN
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic w32, input int hold, input bit disturb);
        logic [63:0] er;
        logic        ec;
        logic        ev;
        int          edges;
        int          exp_lat;
        logic [63:0] r0;
        ref_model(a, b, s, w32, er, ec, ev);
        exp_lat = w32 ? 33 : WIDTH + 1;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        op_a      = a;
        op_b      = b;
        sub       = s;
`ifdef EBPF_ALU32_EN
        alu32     = w32;
`endif
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".busy_run"}, 64'({busy, in_ready}), 64'b10);
        edges = 0;
        while (!out_valid && edges < 200) begin
            if (disturb && edges == 5) begin
                in_valid = 1'b1;
                op_a     = 64'($urandom) << 32 | 64'($urandom);
                op_b     = 64'($urandom);
                sub      = ~s;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 64'(edges + 1), 64'(exp_lat));
        check({tag, ".result"}, result, er);
        check({tag, ".flags"}, 64'({carry_out, overflow}), 64'({ec, ev}));
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_stable"},
                  {r0[63:3] ^ result[63:3], out_valid, in_ready, carry_out ^ ec},
                  {61'd0, 1'b1, 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".idle_after"}, 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int          edges;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
`ifdef EBPF_ALU32_EN
        alu32     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset.status", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset.result", result, 64'd0);
        check("reset.flags", 64'({carry_out, overflow}), 64'd0);

        do_op("add_1_1",   64'd1, 64'd1, 1'b0, 1'b0, 0, 1'b0);
        do_op("add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
        do_op("add_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
        do_op("sub_5_7",   64'd5, 64'd7, 1'b1, 1'b0, 0, 1'b0);
        do_op("sub_7_5",   64'd7, 64'd5, 1'b1, 1'b0, 0, 1'b0);
        do_op("sub_ovf",   64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 0, 1'b0);
        do_op("backpress", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 10, 1'b0);
        do_op("ignore_in", 64'hCAFE_0000_0000_0001, 64'h0000_0000_0000_0003, 1'b1, 1'b0, 0, 1'b1);

        // Reset during RUN cycle 20
        @(negedge clk);
        op_a      = 64'hAAAA_AAAA_AAAA_AAAA;
        op_b      = 64'h5555_5555_5555_5555;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges = 1;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset.status", 64'({in_ready, out_valid, busy}), 64'b100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset.quiet", 64'({in_ready, out_valid, busy}), 64'b100);

        do_op("post_reset", 64'd100, 64'd23, 1'b1, 1'b0, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            ra = {32'($urandom), 32'($urandom)};
            rb = {32'($urandom), 32'($urandom)};
            if (k == 2) rb = ra;
            if (k == 3) begin ra[63] = 1'b0; rb[63] = 1'b0; ra[62] = 1'b1; rb[62] = 1'b1; end
            do_op("rand", ra, rb, 1'($urandom), 1'b0, (k == 5) ? 3 : 0, 1'b0);
        end

`ifdef EBPF_ALU32_EN
        do_op("alu32_dead", 64'hDEAD_BEEF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0, 1'b0);
        do_op("alu32_ovf",  64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b1, 0, 1'b0);
        do_op("alu32_sub",  64'hFFFF_0000_0000_0005, 64'd7, 1'b1, 1'b1, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ra = {32'($urandom), 32'($urandom)};
            rb = {32'($urandom), 32'($urandom)};
            do_op("alu32_rand", ra, rb, 1'($urandom), 1'b1, 0, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ebpf_serial_addsub.md
# ebpf_serial_addsub

Bit-serial WIDTH-bit add/subtract unit for the eBPF core ALU. It accepts two operands through a valid/ready handshake and pushes them LSB-first through a single 1-bit full-adder cell, one bit per clock, with a registered carry. It returns the result, carry and signed-overflow flags through a second valid/ready handshake. It trades latency for area in place of a parallel ripple adder.

## Interface
Parameters:
- WIDTH, 64: operand and result width in bits; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset; one clock, synchronous reset active low
- in_valid  in  1  operands presented
- in_ready  out  1  unit can accept operands
- op_a  in  WIDTH  first operand
- op_b  in  WIDTH  second operand
- sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  sum/difference
- carry_out  out  1  carry out of MSB; for subtract, 1 = no borrow
- overflow  out  1  signed overflow
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch op_a into shift register A and op_b^{WIDTH{sub}} into shift register B.
  - Load carry register with sub, clear bit counter, go to RUN.
- RUN, each cycle:
  - The full-adder cell takes A[0], B[0] and carry.
  - Sum enters the result shift register at the MSB and shifts right.
  - A and B shift right; the cell cout loads the carry register.
  - The counter increments.
  - On the counter's last bit (WIDTH−1), also capture carry-into-MSB (the carry register value before update), then go to DONE.
- DONE:
  - out_valid=1; result, carry_out and overflow are held stable.
  - On out_ready, go to IDLE.
- Flags:
  - carry_out = final carry register.
  - overflow = carry-into-MSB XOR carry_out.
- in_valid outside IDLE is ignored, and operand inputs are not sampled.
- sub is sampled only at accept.
- Counter width is $clog2(WIDTH); it has no wrap-around beyond WIDTH−1.
- Reset mid-operation: a low rst_n at any edge returns the unit to IDLE and discards the partial result.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, carry_out=0, overflow=0.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..WIDTH, processing bit i in cycle i+1.
- out_valid rises in cycle WIDTH+1; latency is WIDTH+1 cycles from accept to first out_valid.
- Output handshake completes at the first edge where out_valid&&out_ready; state is IDLE the next cycle.
- in_ready is combinational from state only (==IDLE), so next accept is no earlier than one cycle after the output handshake.
- Minimum issue interval is WIDTH+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Outputs are registered; result is valid only while out_valid=1, and its contents are unspecified otherwise.

## Configuration
- EBPF_ALU32_EN defined:
  - Adds input port alu32 (1 bit), sampled at accept; requires WIDTH==64.
  - With alu32=1, RUN lasts 32 cycles and the last bit is bit 31.
  - result[31:0] holds the 32-bit sum, and result[63:32] is forced to zero (eBPF ALU32 zero-extension).
  - carry_out and overflow are taken at bit 31.
  - Latency is 33 cycles.
  - With alu32=0, behaviour is identical to the undefined case.
- EBPF_ALU32_EN undefined: no alu32 port; every operation runs WIDTH bits.

## Test plan
- Add 1+1, out_ready=1 → out_valid in cycle 65 after accept; result=2, carry_out=0, overflow=0; next cycle in_ready=1.
- Add 0xFFFF_FFFF_FFFF_FFFF+1 → result=0, carry_out=1, overflow=0.
- Add 0x7FFF_FFFF_FFFF_FFFF+1 → result=0x8000_0000_0000_0000, carry_out=0, overflow=1.
- Subtract 5−7 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0 (borrow), overflow=0; subtract 7−5 → result=2, carry_out=1.
- Back-pressure and ignored input:
  - Hold out_ready=0 for 10 cycles after out_valid → result and flags stable, in_ready=0 throughout.
  - in_valid pulsed during RUN with new operands → ignored; the original result is returned.
- Reset and ALU32:
  - rst_n=0 at RUN cycle 20 → next cycle IDLE, in_ready=1, out_valid=0, busy=0.
  - With EBPF_ALU32_EN, alu32=1, op_a=0xDEAD_BEEF_FFFF_FFFF, op_b=1 → out_valid at cycle 33, result=0, carry_out=1.
